// File: rtl/lsu_data_port_if.sv
// ---------------------------------------------------------------------------
// lsu_data_port_if
//
// Bundles the signals of the load/store unit that face the core and the
// data BRAM. The LSU connects through the slave modport. The master modport
// is the LSU's environment: the core that issues requests and the BRAM
// that returns read data.
//
// Core side : req_valid, req_ready, req_we, req_size, req_unsigned,
//             req_addr, req_wdata, rsp_valid, rsp_rdata, rsp_misaligned
// BRAM side : addr_data, data_out_data, data_in_data, en_data, we_data
// ---------------------------------------------------------------------------
interface lsu_data_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;

    logic [31:0] addr_data;
    logic [31:0] data_out_data;
    logic [31:0] data_in_data;
    logic        en_data;
    logic [3:0]  we_data;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output data_in_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
        input  addr_data, data_out_data, en_data, we_data
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  data_in_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
        output addr_data, data_out_data, en_data, we_data
    );
endinterface

// File: rtl/lsu_data_port.sv
// ---------------------------------------------------------------------------
// lsu_data_port
//
// Load/store unit that owns the data-memory port of the multicycle RV32I
// core. It accepts one byte/half/word request at a time and drives a
// fixed-latency BRAM with byte-lane write enables. Loads are aligned and
// sign- or zero-extended before a one-cycle response is returned.
//
// Parameters:
//   READ_LATENCY : BRAM read latency in clock edges (1..4)
//
// Ports:
//   aclk    : clock, rising edge
//   aresetn : asynchronous active-low reset
//   bus     : lsu_data_port_if.slave (request, response and BRAM signals)
//
// Optional feature (macro LSU_MISALIGN_TRAP_EN):
//   defined   - misaligned half/word requests skip memory and respond with
//               rsp_misaligned=1, rsp_rdata=0
//   undefined - misaligned half/word addresses are silently aligned down,
//               rsp_misaligned is always 0
// ---------------------------------------------------------------------------
module lsu_data_port #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic           aclk,
    input  logic           aresetn,
    lsu_data_port_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        is_store_q, is_store_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  lane_q, lane_d;
    logic        en_q, en_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        mis_q, mis_d;
    logic        misaligned;

`ifdef LSU_MISALIGN_TRAP_EN
    // Sizes 10 and 11 are both words.
    assign misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                        (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Byte-lane enables for a store; the low address bits below the access
    // size are ignored, which is what aligns a misaligned access down.
    function automatic logic [3:0] store_lanes(input logic [1:0] size,
                                               input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << {lane[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the LSB-aligned store data into every lane it may occupy.
    function automatic logic [31:0] store_data(input logic [1:0]  size,
                                               input logic [31:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Select the addressed byte/half from the returned word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic        uns,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_store_d = is_store_q;
        size_d     = size_q;
        uns_d      = uns_q;
        lane_d     = lane_q;
        en_d       = 1'b0;
        we_d       = 4'b0000;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        mis_d      = mis_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    is_store_d = bus.req_we;
                    size_d     = bus.req_size;
                    uns_d      = bus.req_unsigned;
                    lane_d     = bus.req_addr[1:0];
                    addr_d     = {bus.req_addr[31:2], 2'b00};
                    if (misaligned) begin
                        // Rejected: respond straight away, memory untouched.
                        state_d  = S_RESP;
                        rvalid_d = 1'b1;
                        mis_d    = 1'b1;
                        rdata_d  = 32'h0;
                    end else begin
                        // Memory-side outputs are registered here so they
                        // are clean for the whole ISSUE cycle.
                        state_d = S_ISSUE;
                        en_d    = 1'b1;
                        if (bus.req_we) begin
                            we_d    = store_lanes(bus.req_size, bus.req_addr[1:0]);
                            wdata_d = store_data(bus.req_size, bus.req_wdata);
                        end
                    end
                end
            end

            S_ISSUE: begin
                if (is_store_q) begin
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                    mis_d    = 1'b0;
                    rdata_d  = 32'h0;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 3'(READ_LATENCY);
                end
            end

            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // The edge that takes the counter to zero is the one at which
                // the BRAM data is valid.
                if (cnt_q <= 3'd1) begin
                    cnt_d    = 3'd0;
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                    mis_d    = 1'b0;
                    rdata_d  = load_extract(bus.data_in_data, size_q, uns_q, lane_q);
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            is_store_q <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            lane_q     <= 2'b00;
            en_q       <= 1'b0;
            we_q       <= 4'b0000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            rvalid_q   <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_store_q <= is_store_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            lane_q     <= lane_d;
            en_q       <= en_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            mis_q      <= mis_d;
        end
    end

    assign bus.req_ready      = (state_q == S_IDLE);
    assign bus.rsp_valid      = rvalid_q;
    assign bus.rsp_rdata      = rdata_q;
    assign bus.rsp_misaligned = mis_q;
    assign bus.addr_data      = addr_q;
    assign bus.data_out_data  = wdata_q;
    assign bus.en_data        = en_q;
    assign bus.we_data        = we_q;

endmodule

// File: tb/tb_lsu_data_port.sv
// ---------------------------------------------------------------------------
// tb_lsu_data_port
//
// Bench for lsu_data_port. Instance A uses the default READ_LATENCY=1 and
// is exercised with directed and random accesses compared against a
// byte-addressed reference memory. Instance B uses READ_LATENCY=3 to check
// the longer load latency and that requests are ignored while busy.
// Expectations for misaligned accesses follow LSU_MISALIGN_TRAP_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lsu_data_port;

    logic aclk;
    logic aresetn;

    lsu_data_port_if bus_a ();
    lsu_data_port_if bus_b ();

    lsu_data_port #(.READ_LATENCY(1)) dut_a (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus_a.slave)
    );

    lsu_data_port #(.READ_LATENCY(3)) dut_b (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus_b.slave)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ------------------------------------------------------------------
    // BRAM models: byte-lane writes, read data delayed by the latency,
    // garbage on the read bus whenever no read is in flight.
    // ------------------------------------------------------------------
    logic        preload;
    logic [31:0] seed_a [64];
    logic [31:0] seed_b [64];
    logic [31:0] mem_a  [64];
    logic [31:0] mem_b  [64];
    logic [31:0] pipe_a;
    logic [31:0] pipe_b [3];

    always @(posedge aclk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem_a[i] <= seed_a[i];
        end else if (bus_a.en_data) begin
            for (int k = 0; k < 4; k++)
                if (bus_a.we_data[k])
                    mem_a[bus_a.addr_data[7:2]][8*k +: 8] <= bus_a.data_out_data[8*k +: 8];
        end
        pipe_a <= (bus_a.en_data && bus_a.we_data == 4'b0000) ?
                  mem_a[bus_a.addr_data[7:2]] : 32'h0BAD_F00D;
    end
    assign bus_a.data_in_data = pipe_a;

    always @(posedge aclk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem_b[i] <= seed_b[i];
        end else if (bus_b.en_data) begin
            for (int k = 0; k < 4; k++)
                if (bus_b.we_data[k])
                    mem_b[bus_b.addr_data[7:2]][8*k +: 8] <= bus_b.data_out_data[8*k +: 8];
        end
        pipe_b[0] <= (bus_b.en_data && bus_b.we_data == 4'b0000) ?
                     mem_b[bus_b.addr_data[7:2]] : 32'hDEAD_0BAD;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign bus_b.data_in_data = pipe_b[2];

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: byte-addressed memory plus access rules
    // ------------------------------------------------------------------
    logic [7:0] ref_mem [256];

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic model_misaligned(input logic [1:0] size, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
        return (int'(addr[7:0]) % nbytes(size)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // One access on instance A; checks timing, memory-side outputs and the
    // response, and returns the response data.
    task automatic access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
        int          n, base, exp_cyc, rsp_cyc, en_cnt;
        logic        mis;
        logic [31:0] exp_r, exp_do;
        logic [3:0]  exp_we;
        logic [31:0] v;

        n      = nbytes(size);
        mis    = model_misaligned(size, addr);
        base   = int'(addr[7:0]) & ~(n - 1);
        exp_we = 4'(((1 << n) - 1) << (base % 4));
        exp_do = (n == 1) ? {4{wdata[7:0]}} : (n == 2) ? {2{wdata[15:0]}} : wdata;
        exp_r  = 32'h0;
        if (mis) begin
            exp_cyc = 1;
        end else if (we) begin
            exp_cyc = 2;
            for (int i = 0; i < n; i++) ref_mem[base + i] = wdata[8*i +: 8];
        end else begin
            exp_cyc = 3;
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
            if (!uns && n < 4 && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
            exp_r = v;
        end

        bus_a.req_valid    = 1'b1;
        bus_a.req_we       = we;
        bus_a.req_size     = size;
        bus_a.req_unsigned = uns;
        bus_a.req_addr     = addr;
        bus_a.req_wdata    = wdata;
        @(negedge aclk);
        check("req_ready_idle", 32'(bus_a.req_ready), 32'd1);
        @(posedge aclk);
        #1;
        bus_a.req_valid = 1'b0;

        rsp_cyc = 0;
        en_cnt  = 0;
        rdata   = 32'hx;
        for (int c = 1; c <= 12 && rsp_cyc == 0; c++) begin
            @(negedge aclk);
            if (bus_a.en_data) en_cnt++;
            if (c == 1) begin
                check("req_ready_busy", 32'(bus_a.req_ready), 32'd0);
                if (!mis) begin
                    check("addr_data", bus_a.addr_data, {addr[31:2], 2'b00});
                    check("we_data", 32'(bus_a.we_data), we ? 32'(exp_we) : 32'd0);
                    if (we) check("data_out_data", bus_a.data_out_data, exp_do);
                end
            end
            if (bus_a.rsp_valid) begin
                rsp_cyc = c;
                rdata   = bus_a.rsp_rdata;
                check("rsp_rdata", bus_a.rsp_rdata, exp_r);
                check("rsp_misaligned", 32'(bus_a.rsp_misaligned), 32'(mis));
            end
            @(posedge aclk);
            #1;
        end
        check("rsp_cycle", 32'(rsp_cyc), 32'(exp_cyc));
        check("en_data_cycles", 32'(en_cnt), mis ? 32'd0 : 32'd1);
        @(negedge aclk);
        check("rsp_valid_single", 32'(bus_a.rsp_valid), 32'd0);
        check("req_ready_after", 32'(bus_a.req_ready), 32'd1);
        @(posedge aclk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          rsp_cnt, rsp_cyc, en_cnt, we_seen;

        n_checks = 0;
        n_fail   = 0;
        aresetn  = 1'b0;
        preload  = 1'b1;
        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_size = 2'b00;
        bus_a.req_unsigned = 1'b0; bus_a.req_addr = 32'h0; bus_a.req_wdata = 32'h0;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_size = 2'b00;
        bus_b.req_unsigned = 1'b0; bus_b.req_addr = 32'h0; bus_b.req_wdata = 32'h0;
        for (int i = 0; i < 64; i++) begin
            seed_a[i] = $urandom;
            seed_b[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = seed_a[i][8*b +: 8];
        end
        seed_b[12] = 32'h1234_5678;

        repeat (2) @(posedge aclk);
        #1;
        preload = 1'b0;

        // Reset values
        @(negedge aclk);
        check("rst_req_ready", 32'(bus_a.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        check("rst_rsp_misaligned", 32'(bus_a.rsp_misaligned), 32'd0);
        check("rst_en_data", 32'(bus_a.en_data), 32'd0);
        check("rst_we_data", 32'(bus_a.we_data), 32'd0);
        check("rst_addr_data", bus_a.addr_data, 32'd0);
        check("rst_data_out_data", bus_a.data_out_data, 32'd0);
        check("rst_rsp_rdata", bus_a.rsp_rdata, 32'd0);
        check("rst_b_req_ready", 32'(bus_b.req_ready), 32'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Word store then load
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, r);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r);
        check("lw_0x10", r, 32'hDEAD_BEEF);

        // Byte store lane and byte load extension
        access(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00A5, r);
        access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, r);
        check("lb_0x13", r, 32'hFFFF_FFA5);
        access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, r);
        check("lbu_0x13", r, 32'h0000_00A5);

        // Half load extension
        access(1'b1, 2'b10, 1'b0, 32'h20, 32'h8001_7FFF, r);
        access(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, r);
        check("lh_0x22", r, 32'hFFFF_8001);
        access(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, r);
        check("lhu_0x22", r, 32'h0000_8001);
        access(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, r);
        check("lh_0x20", r, 32'h0000_7FFF);

        // Misaligned word
        access(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, r);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw_0x21_trap", r, 32'h0);
`else
        check("lw_0x21_align", r, 32'h8001_7FFF);
`endif

        // Reset during the ISSUE cycle of a store
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1; bus_a.req_size = 2'b10;
        bus_a.req_unsigned = 1'b0; bus_a.req_addr = 32'h40; bus_a.req_wdata = 32'h55AA_55AA;
        @(negedge aclk);
        @(posedge aclk);
        #1;
        bus_a.req_valid = 1'b0;
        #2;
        check("rst_mid_en_before", 32'(bus_a.en_data), 32'd1);
        aresetn = 1'b0;
        #1;
        check("rst_mid_en_data", 32'(bus_a.en_data), 32'd0);
        check("rst_mid_we_data", 32'(bus_a.we_data), 32'd0);
        check("rst_mid_req_ready", 32'(bus_a.req_ready), 32'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        rsp_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            if (bus_a.rsp_valid) rsp_cnt++;
        end
        check("rst_mid_no_rsp", 32'(rsp_cnt), 32'd0);
        @(posedge aclk);
        #1;
        access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, r);
        check("rst_mid_old_value", r, {ref_mem[8'h43], ref_mem[8'h42], ref_mem[8'h41], ref_mem[8'h40]});

        // Random accesses against the reference model
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a, w, rr;
            a  = $urandom;
            w  = $urandom;
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, w, rr);
        end

        // READ_LATENCY=3 load; a request pulse while busy must be ignored
        bus_b.req_valid = 1'b1; bus_b.req_we = 1'b0; bus_b.req_size = 2'b10;
        bus_b.req_unsigned = 1'b0; bus_b.req_addr = 32'h30; bus_b.req_wdata = 32'h0;
        @(negedge aclk);
        check("b_req_ready_idle", 32'(bus_b.req_ready), 32'd1);
        @(posedge aclk);
        #1;
        bus_b.req_valid = 1'b0;
        rsp_cnt = 0; rsp_cyc = 0; en_cnt = 0; we_seen = 0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 2) begin
                bus_b.req_valid = 1'b1; bus_b.req_we = 1'b1;
                bus_b.req_addr = 32'h30; bus_b.req_wdata = 32'hFFFF_FFFF;
            end
            if (c == 3) bus_b.req_valid = 1'b0;
            @(negedge aclk);
            if (bus_b.en_data) en_cnt++;
            if (bus_b.we_data != 4'b0000) we_seen++;
            if (c <= 5) check("b_req_ready_busy", 32'(bus_b.req_ready), 32'd0);
            if (c == 6) check("b_req_ready_after", 32'(bus_b.req_ready), 32'd1);
            if (bus_b.rsp_valid) begin
                rsp_cnt++;
                if (rsp_cyc == 0) begin
                    rsp_cyc = c;
                    check("b_rsp_rdata", bus_b.rsp_rdata, 32'h1234_5678);
                    check("b_rsp_misaligned", 32'(bus_b.rsp_misaligned), 32'd0);
                end
            end
            @(posedge aclk);
            #1;
        end
        check("b_rsp_cycle", 32'(rsp_cyc), 32'd5);
        check("b_rsp_count", 32'(rsp_cnt), 32'd1);
        check("b_en_cycles", 32'(en_cnt), 32'd1);
        check("b_no_write", 32'(we_seen), 32'd0);
        check("b_mem_unchanged", mem_b[12], 32'h1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
